// File: rtl/bg_tile_writer.sv
// bg_tile_writer: queues rectangular map-edit commands and writes one frame-RAM cell per frame_clk
module bg_tile_writer #(
  parameter int MAP_W      = 555,
  parameter int MAP_H      = 56,
  parameter int FIFO_DEPTH = 2,
  parameter int ADDR_W     = 19
) (
  input  logic              frame_clk,
  input  logic              Reset,
  input  logic              dead_reset,
  input  logic              req_valid,
  output logic              req_ready,
  input  logic [9:0]        req_x,
  input  logic [5:0]        req_y,
  input  logic [2:0]        req_w,
  input  logic [2:0]        req_h,
  input  logic [2:0]        req_code,
  output logic              wr_en,
  output logic [ADDR_W-1:0] wr_addr,
  output logic [2:0]        wr_data,
  output logic              busy,
  output logic              done,
  output logic              err
);
  localparam int PW = FIFO_DEPTH > 1 ? $clog2(FIFO_DEPTH) : 1;
  localparam int CW = $clog2(FIFO_DEPTH + 1);

  typedef enum logic [1:0] {IDLE, LOAD, WRITE, DONE} state_t;

  state_t              r_state, w_next;
  logic [24:0]         r_mem [FIFO_DEPTH];
  logic [PW-1:0]       r_rd, r_wr;
  logic [CW-1:0]       r_count;
  logic [24:0]         r_cmd;
  logic [2:0]          r_col, r_row, r_data;
  logic [ADDR_W-1:0]   r_row_base, r_addr;
  logic                r_err;
  logic                w_accept, w_legal, w_push, w_pop, w_col_end, w_row_end;
  logic [ADDR_W-1:0]   w_base;

  // r_cmd layout: {x[24:15], y[14:9], w[8:6], h[5:3], code[2:0]}
  assign req_ready = r_count < CW'(FIFO_DEPTH);
  assign w_accept  = req_valid && req_ready && !dead_reset;
  assign w_legal   = req_w != 3'd0 && req_h != 3'd0 && req_code != 3'd7 &&
                     int'(req_x) + int'(req_w) <= MAP_W && int'(req_y) + int'(req_h) <= MAP_H;
  assign w_push    = w_accept && w_legal;
  assign w_pop     = r_state == IDLE && r_count != '0 && !dead_reset;
  assign w_col_end = r_col == r_cmd[8:6] - 3'd1;
  assign w_row_end = r_row == r_cmd[5:3] - 3'd1;
  assign w_base    = ADDR_W'(r_cmd[14:9]) * ADDR_W'(MAP_W) + ADDR_W'(r_cmd[24:15]);

  assign wr_en   = r_state == WRITE;
  assign done    = r_state == DONE;
  assign busy    = r_state != IDLE || r_count != '0;
  assign err     = r_err;
  assign wr_addr = r_addr;
  assign wr_data = r_data;

  always_ff @(posedge frame_clk)
    if (w_push) r_mem[r_wr] <= {req_x, req_y, req_w, req_h, req_code};

  always_ff @(posedge frame_clk or posedge Reset)
    if (Reset || dead_reset) begin
      r_rd    <= '0;
      r_wr    <= '0;
      r_count <= '0;
      r_err   <= 1'b0;
    end else begin
      r_err   <= w_accept && !w_legal;
      r_wr    <= r_wr + PW'(w_push);
      r_rd    <= r_rd + PW'(w_pop);
      r_count <= r_count + CW'(w_push) - CW'(w_pop);
    end

  always_ff @(posedge frame_clk or posedge Reset)
    if (Reset) r_state <= IDLE;
    else r_state <= w_next;

  always_comb begin
    w_next = r_state;
    w_next = dead_reset         ? IDLE :
             r_state == IDLE    ? (r_count != '0 ? LOAD : IDLE) :
             r_state == LOAD    ? WRITE :
             r_state == WRITE   ? (w_col_end && w_row_end ? DONE : WRITE) : IDLE;
  end

  // wr_addr/wr_data are loaded on the edge into WRITE so the first write is valid immediately
  always_ff @(posedge frame_clk or posedge Reset)
    if (Reset || dead_reset) begin
      r_cmd      <= '0;
      r_col      <= '0;
      r_row      <= '0;
      r_row_base <= '0;
      r_addr     <= '0;
      r_data     <= '0;
    end else begin
      if (w_pop) r_cmd <= r_mem[r_rd];
      if (r_state == LOAD) begin
        r_row_base <= w_base;
        r_addr     <= w_base;
        r_data     <= r_cmd[2:0];
        r_col      <= '0;
        r_row      <= '0;
      end else if (r_state == WRITE) begin
        if (!w_col_end) begin
          r_col  <= r_col + 3'd1;
          r_addr <= r_addr + ADDR_W'(1);
        end else if (!w_row_end) begin
          r_col      <= '0;
          r_row      <= r_row + 3'd1;
          r_row_base <= r_row_base + ADDR_W'(MAP_W);
          r_addr     <= r_row_base + ADDR_W'(MAP_W);
        end
      end
    end
endmodule

// File: tb/tb_bg_tile_writer.sv
// tb_bg_tile_writer: random and directed map edits checked against a command-level model of the writer
module tb_bg_tile_writer;
  logic        frame_clk = 1'b0;
  logic        Reset, dead_reset = 1'b0, req_valid = 1'b0;
  logic [9:0]  req_x = '0;
  logic [5:0]  req_y = '0;
  logic [2:0]  req_w = '0, req_h = '0, req_code = '0;
  logic        req_ready, wr_en, busy, done, err;
  logic [18:0] wr_addr;
  logic [2:0]  wr_data;

  bg_tile_writer dut (
    .frame_clk(frame_clk), .Reset(Reset), .dead_reset(dead_reset),
    .req_valid(req_valid), .req_ready(req_ready), .req_x(req_x), .req_y(req_y),
    .req_w(req_w), .req_h(req_h), .req_code(req_code),
    .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
    .busy(busy), .done(done), .err(err)
  );

  always #5 frame_clk = ~frame_clk;

  typedef struct {bit en; bit dn; int addr; int data;} ent_t;
  typedef struct {int x; int y; int w; int h; int c;} cmd_t;

  cmd_t mq[$];
  ent_t sched[$];
  bit   m_err;
  int   hold_a, hold_d;
  int   checks = 0, failures = 0, cyc = 0;
  int   wlog[$], wcyc[$], wdat[$], dn_cyc[$];
  int   dn_cnt = 0, err_cnt = 0;

  function automatic bit legal(cmd_t c);
    return c.w > 0 && c.h > 0 && c.x + c.w <= 555 && c.y + c.h <= 56 && c.c <= 6;
  endfunction

  function automatic void m_clear();
    mq.delete();
    sched.delete();
    m_err  = 0;
    hold_a = 0;
    hold_d = 0;
  endfunction

  // The model expands each popped command into its cycle-by-cycle output stream:
  // one load cycle, w*h writes in row-major order, one done cycle.
  function automatic void m_step();
    cmd_t c, p;
    bit rdy  = mq.size() < 2;
    bit idle = sched.size() == 0;
    if (dead_reset) begin
      m_clear();
      return;
    end
    if (!idle) sched.delete(0);
    else if (mq.size() > 0) begin
      p = mq.pop_front();
      sched.push_back('{0, 0, hold_a, hold_d});
      for (int r = 0; r < p.h; r++)
        for (int k = 0; k < p.w; k++) begin
          hold_a = (p.y + r) * 555 + p.x + k;
          hold_d = p.c;
          sched.push_back('{1, 0, hold_a, hold_d});
        end
      sched.push_back('{0, 1, hold_a, hold_d});
    end
    m_err = 0;
    if (req_valid && rdy) begin
      c = '{int'(req_x), int'(req_y), int'(req_w), int'(req_h), int'(req_code)};
      if (legal(c)) mq.push_back(c);
      else m_err = 1;
    end
  endfunction

  always @(posedge frame_clk) cyc++;

  always @(posedge frame_clk or posedge Reset)
    if (Reset) m_clear();
    else m_step();

  always @(negedge frame_clk) begin
    ent_t e;
    logic [26:0] exp_v, act_v;
    e = sched.size() > 0 ? sched[0] : '{0, 0, hold_a, hold_d};
    exp_v = {e.en, e.dn, m_err, (sched.size() > 0 || mq.size() > 0), (mq.size() < 2),
             19'(e.addr), 3'(e.data)};
    act_v = {wr_en, done, err, busy, req_ready, wr_addr, wr_data};
    checks++;
    if (act_v !== exp_v) begin
      failures++;
      $display("FAIL cycle_compare cyc=%0d got en=%0b done=%0b err=%0b busy=%0b rdy=%0b addr=%0d data=%0d expected en=%0b done=%0b err=%0b busy=%0b rdy=%0b addr=%0d data=%0d",
               cyc, act_v[26], act_v[25], act_v[24], act_v[23], act_v[22], act_v[21:3], act_v[2:0],
               exp_v[26], exp_v[25], exp_v[24], exp_v[23], exp_v[22], exp_v[21:3], exp_v[2:0]);
    end
    if (wr_en) begin
      wlog.push_back(int'(wr_addr));
      wcyc.push_back(cyc);
      wdat.push_back(int'(wr_data));
    end
    if (done) begin
      dn_cnt++;
      dn_cyc.push_back(cyc);
    end
    if (err) err_cnt++;
  end

  task automatic chk(input string name, input longint act, input longint exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got %0d expected %0d", name, act, exp);
    end
  endtask

  task automatic step(input bit v, input int x, y, w, h, c, input bit dr);
    req_valid  = v;
    req_x      = 10'(x);
    req_y      = 6'(y);
    req_w      = 3'(w);
    req_h      = 3'(h);
    req_code   = 3'(c);
    dead_reset = dr;
    @(posedge frame_clk);
    #1;
    req_valid  = 1'b0;
    dead_reset = 1'b0;
  endtask

  task automatic idle(input int n);
    repeat (n) step(0, 0, 0, 0, 0, 0, 0);
  endtask

  task automatic send(input int x, y, w, h, c);
    bit acc;
    for (int t = 0; t < 500; t++) begin
      acc = req_ready;
      step(1, x, y, w, h, c, 0);
      if (acc) return;
    end
    chk("send_timeout", 0, 1);
  endtask

  task automatic clr_logs();
    wlog.delete();
    wcyc.delete();
    wdat.delete();
    dn_cyc.delete();
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog expired at cyc=%0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int e0, n0, r, w, h;
    Reset = 1'b1;
    repeat (3) @(posedge frame_clk);
    #1 Reset = 1'b0;
    idle(1);
    chk("rst_wr_en", wr_en, 0);
    chk("rst_ready", req_ready, 1);
    chk("rst_busy", busy, 0);
    chk("rst_addr", wr_addr, 0);

    clr_logs();
    send(100, 10, 2, 2, 5);
    e0 = cyc;
    idle(8);
    chk("t1_nwrites", wlog.size(), 4);
    chk("t1_a0", wlog[0], 5650);
    chk("t1_a1", wlog[1], 5651);
    chk("t1_a2", wlog[2], 6205);
    chk("t1_a3", wlog[3], 6206);
    chk("t1_data", wdat[0], 5);
    chk("t1_first_cyc", wcyc[0], e0 + 2);
    chk("t1_last_cyc", wcyc[3], e0 + 5);
    chk("t1_done_cyc", dn_cyc[0], e0 + 6);
    chk("t1_busy_after", busy, 0);

    clr_logs();
    send(554, 55, 1, 1, 6);
    idle(5);
    chk("t2_nwrites", wlog.size(), 1);
    chk("t2_corner", wlog[0], 31079);
    n0 = err_cnt;
    send(554, 55, 2, 1, 6);
    idle(4);
    chk("t2_err", err_cnt - n0, 1);
    chk("t2_nowrite", wlog.size(), 1);
    chk("t2_ready", req_ready, 1);
    chk("t2_busy", busy, 0);

    clr_logs();
    n0 = dn_cnt;
    send(0, 0, 2, 1, 1);
    send(10, 1, 1, 2, 2);
    send(3, 3, 3, 1, 3);
    chk("t3_full", req_ready, 0);
    send(20, 20, 1, 1, 4);
    idle(30);
    chk("t3_dones", dn_cnt - n0, 4);
    chk("t3_nwrites", wlog.size(), 8);
    chk("t3_a_first", wlog[0], 0);
    chk("t3_b_first", wlog[2], 565);
    chk("t3_c_first", wlog[4], 1668);
    chk("t3_d", wlog[7], 11120);

    clr_logs();
    n0 = err_cnt;
    send(0, 0, 0, 1, 1);
    send(0, 0, 1, 0, 1);
    send(0, 0, 1, 1, 7);
    chk("t4_busy", busy, 0);
    idle(3);
    chk("t4_errs", err_cnt - n0, 3);
    chk("t4_nwrites", wlog.size(), 0);

    clr_logs();
    n0 = dn_cnt;
    step(1, 5, 5, 4, 2, 2, 0);
    step(1, 7, 7, 1, 1, 3, 0);
    idle(3);
    step(1, 9, 9, 1, 1, 1, 1);
    chk("t5_wr_en", wr_en, 0);
    chk("t5_busy", busy, 0);
    chk("t5_ready", req_ready, 1);
    chk("t5_done", done, 0);
    idle(10);
    chk("t5_nwrites", wlog.size(), 3);
    chk("t5_a2", wlog[2], 2782);
    chk("t5_nodone", dn_cnt - n0, 0);

    send(10, 2, 4, 2, 1);
    idle(3);
    #2 Reset = 1'b1;
    #1;
    chk("t6_wr_en", wr_en, 0);
    chk("t6_busy", busy, 0);
    chk("t6_done", done, 0);
    @(posedge frame_clk);
    #1 Reset = 1'b0;
    clr_logs();
    send(30, 4, 1, 1, 2);
    e0 = cyc;
    idle(5);
    chk("t6_nwrites", wlog.size(), 1);
    chk("t6_addr", wlog[0], 2250);
    chk("t6_first_cyc", wcyc[0], e0 + 2);

    repeat (400) begin
      r = $urandom_range(0, 99);
      if (r < 3) step(1, $urandom_range(0, 540), $urandom_range(0, 50), 2, 2, 1, 1);
      else if (r < 35) idle($urandom_range(1, 3));
      else if (r < 90) begin
        w = $urandom_range(1, 7);
        h = $urandom_range(1, 7);
        send($urandom_range(0, 555 - w), $urandom_range(0, 56 - h), w, h, $urandom_range(0, 6));
      end else
        send($urandom_range(0, 1023), $urandom_range(0, 63), $urandom_range(0, 7),
             $urandom_range(0, 7), $urandom_range(0, 7));
    end
    idle(120);
    chk("final_busy", busy, 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule
